mcycle_issue_ctrl: RTL

//  Sequencer between the EX stage and the MCycle multi-cycle mul/div unit.
//  - Decodes RV32M funct3 into MCycleOp, drives the Start/Busy handshake and captures results.
//  - Resolves div-by-zero and signed overflow locally, and builds MULHSU from an unsigned multiply.
//  - Holds a one-entry result cache so paired ops (DIV+REM, MULH+MUL) on the same operands skip MCycle.

---
 rtl/mcycle_issue_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mcycle_issue_ctrl.sv
// Issue sequencer between EX and the MCycle mul/div unit: decodes RV32M funct3,
// runs the Start/Busy handshake, resolves div corner cases and reuses paired results.
module mcycle_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 5,
  parameter int CACHE_EN = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             stall,
  output logic             mc_start,
  output logic [1:0]       mc_op,
  output logic [WIDTH-1:0] mc_op1,
  output logic [WIDTH-1:0] mc_op2,
  input  logic [WIDTH-1:0] mc_result1,
  input  logic [WIDTH-1:0] mc_result2,
  input  logic             mc_busy
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [2:0]       funct3_r;
  logic [WIDTH-1:0] rs1_r;
  logic [WIDTH-1:0] rs2_r;

  logic             cache_vld_r;
  logic [1:0]       cache_op_r;
  logic [WIDTH-1:0] cache_a_r;
  logic [WIDTH-1:0] cache_b_r;
  logic [WIDTH-1:0] cache_r1_r;
  logic [WIDTH-1:0] cache_r2_r;

  logic [1:0]       op_s;
  logic             is_div_s;
  logic             div_zero_s;
  logic             div_ovf_s;
  logic             hit_s;
  logic             fast_s;
  logic [WIDTH-1:0] fast_data_s;
  logic [WIDTH-1:0] wait_data_s;
  logic             accept_s;
  logic             capture_s;

  function automatic logic [1:0] decode_op(input logic [2:0] f3);
    logic [1:0] op;
    case (f3)
      3'b000, 3'b001: op = 2'b00;
      3'b010, 3'b011: op = 2'b01;
      3'b100, 3'b110: op = 2'b10;
      3'b101, 3'b111: op = 2'b11;
      default:        op = 2'b00;
    endcase
    return op;
  endfunction

  // MULHSU comes from an unsigned multiply: subtract rs2 from the high word when rs1 is negative.
  function automatic logic [WIDTH-1:0] form_result(
    input logic [2:0]       f3,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r1,
    input logic [WIDTH-1:0] r2
  );
    logic [WIDTH-1:0] res;
    case (f3)
      3'b000, 3'b100, 3'b101: res = r1;
      3'b010:                 res = r2 - (a[WIDTH-1] ? b : {WIDTH{1'b0}});
      3'b001, 3'b011,
      3'b110, 3'b111:         res = r2;
      default:                res = r2;
    endcase
    return res;
  endfunction

  // Request decode, corner-case detection and cache lookup.
  always_comb begin
    op_s        = decode_op(req_funct3);
    is_div_s    = req_funct3[2];
    div_zero_s  = is_div_s && (req_rs2 == {WIDTH{1'b0}});
    div_ovf_s   = is_div_s && !req_funct3[0] &&
                  (req_rs1 == SMIN) && (req_rs2 == {WIDTH{1'b1}});
    hit_s       = (CACHE_EN != 0) && cache_vld_r && (cache_op_r == op_s) &&
                  (cache_a_r == req_rs1) && (cache_b_r == req_rs2);
    fast_s      = div_zero_s || div_ovf_s || hit_s;
    accept_s    = (state_r == ST_IDLE) && req_valid;
    capture_s   = (state_r == ST_WAIT) && !mc_busy;
    wait_data_s = form_result(funct3_r, rs1_r, rs2_r, mc_result1, mc_result2);
    if (div_zero_s) begin
      fast_data_s = req_funct3[1] ? req_rs1 : {WIDTH{1'b1}};
    end else if (div_ovf_s) begin
      fast_data_s = req_funct3[1] ? {WIDTH{1'b0}} : req_rs1;
    end else begin
      fast_data_s = form_result(req_funct3, req_rs1, req_rs2, cache_r1_r, cache_r2_r);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_DRAIN: begin
        if (!mc_busy) state_s = ST_IDLE;
        else          state_s = ST_DRAIN;
      end
      ST_IDLE: begin
        if (req_valid) state_s = fast_s ? ST_RESP : ST_ISSUE;
        else           state_s = ST_IDLE;
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (!mc_busy) state_s = ST_RESP;
        else          state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (resp_ready) state_s = ST_IDLE;
        else            state_s = ST_RESP;
      end
      default: state_s = ST_DRAIN;
    endcase
  end

  // State register and handshake flags, registered from the next state so they track it exactly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_DRAIN;
      req_ready  <= 1'b0;
      stall      <= 1'b1;
      mc_start   <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state_r    <= state_s;
      req_ready  <= (state_s == ST_IDLE);
      stall      <= (state_s != ST_IDLE);
      mc_start   <= (state_s == ST_ISSUE);
      resp_valid <= (state_s == ST_RESP);
    end
  end

  // Request latch, MCycle operands (held until the next issue) and response data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      funct3_r  <= 3'b000;
      rs1_r     <= {WIDTH{1'b0}};
      rs2_r     <= {WIDTH{1'b0}};
      resp_data <= {WIDTH{1'b0}};
      resp_tag  <= {TAG_W{1'b0}};
      mc_op     <= 2'b00;
      mc_op1    <= {WIDTH{1'b0}};
      mc_op2    <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        funct3_r <= req_funct3;
        rs1_r    <= req_rs1;
        rs2_r    <= req_rs2;
        resp_tag <= req_tag;
        if (fast_s) begin
          resp_data <= fast_data_s;
        end else begin
          mc_op  <= op_s;
          mc_op1 <= req_rs1;
          mc_op2 <= req_rs2;
        end
      end else if (capture_s) begin
        resp_data <= wait_data_s;
      end else begin
        resp_data <= resp_data;
      end
    end
  end

  // One-entry result cache, filled only by an MCycle completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cache_vld_r <= 1'b0;
      cache_op_r  <= 2'b00;
      cache_a_r   <= {WIDTH{1'b0}};
      cache_b_r   <= {WIDTH{1'b0}};
      cache_r1_r  <= {WIDTH{1'b0}};
      cache_r2_r  <= {WIDTH{1'b0}};
    end else begin
      if (capture_s && (CACHE_EN != 0)) begin
        cache_vld_r <= 1'b1;
        cache_op_r  <= mc_op;
        cache_a_r   <= mc_op1;
        cache_b_r   <= mc_op2;
        cache_r1_r  <= mc_result1;
        cache_r2_r  <= mc_result2;
      end else begin
        cache_vld_r <= cache_vld_r;
      end
    end
  end

endmodule
